// File: rtl/processor.sv
// Single-cycle 32-bit register-to-register core.
// The opcode is decoded into an ALU select and a write enable. Operands are
// read combinationally from a 32x32 register file. On every rising edge the
// ALU output is registered on `result` and written back to R[rd].
// There is no handshake: one instruction is taken on every rising edge
// outside reset, and the caller keeps `instruction` stable around that edge.
module processor (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] result
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_NONE = 4'd8
  } alu_op_e;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        unused_low_bits;

  assign opcode          = instruction[31:26];
  assign rs              = instruction[25:21];
  assign rt              = instruction[20:16];
  assign rd              = instruction[15:11];
  assign unused_low_bits = ^instruction[10:0];

  logic [31:0] regs_q [32];
  logic [31:0] result_q, result_d;
  logic [31:0] op_a, op_b;
  alu_op_e     alu_op;
  logic        we;

  // R0 always reads as zero, whatever the array entry holds.
  assign op_a = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign op_b = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  // Control unit: opcode to ALU select and write enable; unknown opcodes are NOPs.
  always_comb begin
    alu_op = ALU_NONE;
    we     = 1'b0;
    case (opcode)
      6'b000000: begin alu_op = ALU_ADD; we = 1'b1; end
      6'b000001: begin alu_op = ALU_SUB; we = 1'b1; end
      6'b000010: begin alu_op = ALU_AND; we = 1'b1; end
      6'b000011: begin alu_op = ALU_OR;  we = 1'b1; end
      6'b000100: begin alu_op = ALU_XOR; we = 1'b1; end
      6'b000101: begin alu_op = ALU_SLT; we = 1'b1; end
      6'b000110: begin alu_op = ALU_SLL; we = 1'b1; end
      6'b000111: begin alu_op = ALU_SRL; we = 1'b1; end
      default:   begin alu_op = ALU_NONE; we = 1'b0; end
    endcase
  end

  // ALU: the shift amount is taken from the low five bits of B only.
  always_comb begin
    result_d = 32'd0;
    case (alu_op)
      ALU_ADD: result_d = op_a + op_b;
      ALU_SUB: result_d = op_a - op_b;
      ALU_AND: result_d = op_a & op_b;
      ALU_OR:  result_d = op_a | op_b;
      ALU_XOR: result_d = op_a ^ op_b;
      ALU_SLT: result_d = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      ALU_SLL: result_d = op_a << op_b[4:0];
      ALU_SRL: result_d = op_a >> op_b[4:0];
      default: result_d = 32'd0;
    endcase
  end

  // Result register and writeback. Reset loads R[i] = i so that operands are
  // known without a load path. The read above sees the old value, and the new
  // value is visible to the next instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'(i);
      end
    end else begin
      result_q <= result_d;
      if (we && (rd != 5'd0)) begin
        regs_q[rd] <= result_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_processor.sv
// Directed bench for the single-cycle core: hand-computed results for each
// opcode, writeback dependencies, R0 behaviour, NOPs, and asynchronous reset.
module tb_processor;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  processor dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .result      (result)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3,
                         OP_XOR = 6'd4, OP_SLT = 6'd5, OP_SLL = 6'd6, OP_SRL = 6'd7,
                         OP_BAD = 6'h3F;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present the instruction at the falling edge, then check after the rising edge
  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] exp);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
    check(tag, result, exp);
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 32'hxxxx_xxxx;
    #10;
    check("reset_result", result, 32'd0);
    @(negedge clk);
    instruction = mk(OP_BAD, 5'd0, 5'd0, 5'd0);
    reset       = 1'b0;
    @(posedge clk);
    #1;
    check("nop_after_reset", result, 32'd0);

    // Basic ops on reset register contents
    step("add_r0_r1",      32'h0001_0000, 32'd1);
    step("r0_still_zero",  mk(OP_ADD, 5'd0, 5'd0, 5'd10), 32'd0);
    step("sub_wrap",       32'h0401_0000, 32'hFFFF_FFFF);
    step("or_r0_r1",       32'h0C01_0000, 32'd1);

    // Unknown opcode: zero result, no write even with rd set
    step("nop_result",     32'hFC00_0000, 32'd0);
    step("nop_rd5",        mk(OP_BAD, 5'd1, 5'd2, 5'd5), 32'd0);
    step("r5_unchanged",   mk(OP_ADD, 5'd5, 5'd0, 5'd0), 32'd5);
    step("add_r1_r2_rd3",  32'h0022_1800, 32'd3);

    // Writeback and back-to-back dependency
    step("add_5_6_rd7",    mk(OP_ADD, 5'd5, 5'd6, 5'd7), 32'd11);
    step("add_7_7_rd8",    mk(OP_ADD, 5'd7, 5'd7, 5'd8), 32'd22);
    step("rdw_old_r8",     mk(OP_ADD, 5'd8, 5'd8, 5'd8), 32'd44);
    step("r8_new",         mk(OP_ADD, 5'd8, 5'd0, 5'd0), 32'd44);
    step("slt_1_2",        mk(OP_SLT, 5'd1, 5'd2, 5'd0), 32'd1);
    step("slt_2_1",        mk(OP_SLT, 5'd2, 5'd1, 5'd0), 32'd0);
    step("sll_1_4",        mk(OP_SLL, 5'd1, 5'd4, 5'd0), 32'd16);
    step("srl_31_1",       mk(OP_SRL, 5'd31, 5'd1, 5'd0), 32'd15);
    step("and_3_6",        mk(OP_AND, 5'd3, 5'd6, 5'd0), 32'd2);
    step("xor_5_6",        mk(OP_XOR, 5'd5, 5'd6, 5'd0), 32'd3);

    // Sign and overflow
    step("sub_rd9",        mk(OP_SUB, 5'd0, 5'd1, 5'd9), 32'hFFFF_FFFF);
    step("slt_neg1_1",     mk(OP_SLT, 5'd9, 5'd1, 5'd0), 32'd1);
    step("slt_1_neg1",     mk(OP_SLT, 5'd1, 5'd9, 5'd0), 32'd0);
    step("add_overflow",   mk(OP_ADD, 5'd9, 5'd1, 5'd0), 32'd0);
    step("sll_amt_5bit",   mk(OP_SLL, 5'd1, 5'd9, 5'd0), 32'h8000_0000);
    step("srl_logical",    mk(OP_SRL, 5'd9, 5'd31, 5'd0), 32'd1);

    // Writes to R0 are discarded
    step("add_rd0",        mk(OP_ADD, 5'd5, 5'd6, 5'd0), 32'd11);
    step("r0_after_write", mk(OP_ADD, 5'd0, 5'd0, 5'd0), 32'd0);

    // Asynchronous reset mid-stream, between edges
    step("pre_reset",      mk(OP_ADD, 5'd7, 5'd0, 5'd0), 32'd11);
    #2;
    reset       = 1'b1;
    instruction = 32'hxxxx_xxxx;
    #1;
    check("async_reset", result, 32'd0);
    @(posedge clk);
    #1;
    check("held_in_reset", result, 32'd0);
    @(negedge clk);
    instruction = mk(OP_BAD, 5'd0, 5'd0, 5'd0);
    reset       = 1'b0;
    step("r7_restored",    mk(OP_ADD, 5'd7, 5'd0, 5'd0), 32'd7);
    step("r8_restored",    mk(OP_ADD, 5'd8, 5'd0, 5'd0), 32'd8);
    step("r9_restored",    mk(OP_ADD, 5'd9, 5'd0, 5'd0), 32'd9);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
